// File: rtl/wb_interconnect_1xn_to.sv
// 1-master / N-slave Wishbone interconnect with registered decode, locked slave selection,
// an error responder for unmapped addresses and a per-access slave-response watchdog.
module wb_interconnect_1xn_to #(
    parameter int                                   WB_ADDR_WIDTH  = 32,
    parameter int                                   WB_DATA_WIDTH  = 32,
    parameter int                                   N_SLAVES       = 6,
    parameter logic [N_SLAVES*2*WB_ADDR_WIDTH-1:0]  ADDR_RANGES    = '0,
    parameter int                                   TIMEOUT_CYCLES = 256
) (
    input  logic                                    clk,
    input  logic                                    rst,
    // master side
    input  logic [WB_ADDR_WIDTH-1:0]                m_adr,
    input  logic [WB_DATA_WIDTH-1:0]                m_dat_w,
    input  logic [WB_DATA_WIDTH/8-1:0]              m_sel,
    input  logic [2:0]                              m_cti,
    input  logic [1:0]                              m_bte,
    input  logic                                    m_cyc,
    input  logic                                    m_stb,
    input  logic                                    m_we,
    output logic [WB_DATA_WIDTH-1:0]                m_dat_r,
    output logic                                    m_ack,
    output logic                                    m_err,
    // slave side, slot i = [i*W +: W]
    output logic [N_SLAVES*WB_ADDR_WIDTH-1:0]       s_adr,
    output logic [N_SLAVES*WB_DATA_WIDTH-1:0]       s_dat_w,
    output logic [N_SLAVES*WB_DATA_WIDTH/8-1:0]     s_sel,
    output logic [N_SLAVES*3-1:0]                   s_cti,
    output logic [N_SLAVES*2-1:0]                   s_bte,
    output logic [N_SLAVES-1:0]                     s_cyc,
    output logic [N_SLAVES-1:0]                     s_stb,
    output logic [N_SLAVES-1:0]                     s_we,
    input  logic [N_SLAVES*WB_DATA_WIDTH-1:0]       s_dat_r,
    input  logic [N_SLAVES-1:0]                     s_ack,
    input  logic [N_SLAVES-1:0]                     s_err,
    // status
    output logic                                    err_unmapped,
    output logic                                    err_timeout,
    output logic                                    busy
);

    localparam int AW    = WB_ADDR_WIDTH;
    localparam int DW    = WB_DATA_WIDTH;
    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LIMIT = WD_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_ABORT
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err_q;
    logic               r_err_unmapped;
    logic               r_err_timeout;

    logic               w_hit;
    logic [SEL_W-1:0]   w_hit_idx;
    logic               w_sel_ack;
    logic               w_sel_err;
    logic [DW-1:0]      w_sel_dat;
    logic               w_active;

    // Scan from the top index down so the lowest matching slave overrides on overlap.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (m_adr >= ADDR_RANGES[(N_SLAVES-1-i)*2*AW + AW +: AW] &&
                m_adr <= ADDR_RANGES[(N_SLAVES-1-i)*2*AW +: AW]) begin
                w_hit     = 1'b1;
                w_hit_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        w_sel_ack = 1'b0;
        w_sel_err = 1'b0;
        w_sel_dat = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_sel_ack = s_ack[i];
                w_sel_err = s_err[i];
                w_sel_dat = s_dat_r[i*DW +: DW];
            end
        end
    end

    assign w_active = (r_state == S_ACTIVE) && m_cyc;

    always_comb begin
        s_cyc = '0;
        s_stb = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (w_active && r_sel == SEL_W'(i)) begin
                s_cyc[i] = 1'b1;
                s_stb[i] = m_stb;
            end
        end
    end

    assign s_adr   = {N_SLAVES{m_adr}};
    assign s_dat_w = {N_SLAVES{m_dat_w}};
    assign s_sel   = {N_SLAVES{m_sel}};
    assign s_cti   = {N_SLAVES{m_cti}};
    assign s_bte   = {N_SLAVES{m_bte}};
    assign s_we    = {N_SLAVES{m_we}};

    // ACK wins if a slave raises both, so the master never sees ACK and ERR together.
    assign m_ack        = w_active & w_sel_ack;
    assign m_err        = w_active ? (w_sel_err & ~w_sel_ack)
                                   : ((r_state == S_ABORT) & r_err_q);
    assign m_dat_r      = (r_state == S_ACTIVE) ? w_sel_dat : '0;
    assign busy         = (r_state != S_IDLE);
    assign err_unmapped = r_err_unmapped;
    assign err_timeout  = r_err_timeout;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_sel          <= '0;
            r_cnt          <= '0;
            r_err_q        <= 1'b0;
            r_err_unmapped <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_err_unmapped <= 1'b0;
            r_err_timeout  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt   <= '0;
                    r_err_q <= 1'b0;
                    if (m_cyc && m_stb) begin
                        if (w_hit) begin
                            r_state <= S_ACTIVE;
                            r_sel   <= w_hit_idx;
                        end else begin
                            r_state        <= S_ABORT;
                            r_err_unmapped <= 1'b1;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (!m_cyc) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_sel_ack || w_sel_err || !m_stb) begin
                        r_cnt <= '0;
                    end else if (WD_EN && r_cnt == CNT_LIMIT) begin
                        // The stalled strobe is answered with ERR in the same cycle the abort is flagged.
                        r_state       <= S_ABORT;
                        r_err_timeout <= 1'b1;
                        r_err_q       <= 1'b1;
                        r_cnt         <= '0;
                    end else if (WD_EN) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ABORT: begin
                    if (!m_cyc) begin
                        r_state <= S_IDLE;
                        r_err_q <= 1'b0;
                    end else begin
                        r_err_q <= m_stb & ~r_err_q;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
